// File: rtl/des_round_engine.sv
// des_round_engine: iterative DES Feistel round engine.
// Holds the L/R halves of one block, exposes R to the external f-function
// (expansion, key XOR, S-boxes, P-box) and folds the returned P-box value
// back in, one round per clock, for 16 rounds. The pre-output block
// {R16, L16} is then offered downstream until it is taken.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE and does not depend on in_valid.
// out_valid is high only in DONE, does not depend on out_ready, and once
// raised it stays high with out_block stable until the transfer edge.
module des_round_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_block,
    input  logic        decrypt,
    output logic [31:0] f_r,
    output logic [3:0]  key_sel,
    input  logic [31:0] f_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_block,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic [3:0]  r_cnt;
    logic        r_dec;
    logic        w_load;
    logic        w_round;

    // State register; reset returns the engine to IDLE and drops any block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake/control outputs, decoded from the current state.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        out_valid    = 1'b0;
        key_sel      = 4'd0;
        w_load       = 1'b0;
        w_round      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_next_state = S_ROUND;
                end
            end
            S_ROUND: begin
                busy    = 1'b1;
                w_round = 1'b1;
                // Decryption walks the same subkeys in reverse order.
                key_sel = r_dec ? (4'd15 - r_cnt) : r_cnt;
                // cnt == 15 is the 16th and final round.
                if (r_cnt == 4'd15) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Block datapath: load on accept, one Feistel round per ROUND cycle,
    // hold otherwise (the result stays in L/R after the output handshake).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_l   <= 32'd0;
            r_r   <= 32'd0;
            r_cnt <= 4'd0;
            r_dec <= 1'b0;
        end else if (w_load) begin
            r_l   <= in_block[63:32];
            r_r   <= in_block[31:0];
            r_cnt <= 4'd0;
            r_dec <= decrypt;
        end else if (w_round) begin
            r_l   <= r_r;
            r_r   <= r_l ^ f_p;
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // The final DES round is not followed by a swap, so the halves are
    // exchanged here on the way out.
    assign out_block = {r_r, r_l};
    assign f_r       = r_r;
    assign dbg_state = r_state;

endmodule

// File: doc/des_round_engine.md
# des_round_engine

Iterative DES Feistel round engine, directly downstream of the permutation-box stage. It holds the L/R halves of one block and presents R to the external f-function path (expansion, key XOR, S-boxes, P-box). Each round it consumes the P-box result and applies L' = R, R' = L ^ f. After 16 rounds it delivers the pre-output block R16‖L16 to the final-permutation stage through a valid/ready handshake.

## Interface
- No parameters; the round count is fixed at 16 and the block width at 64.
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has a block; post-IP data on in_block
- in_ready  out  1  engine can accept a block; high only in IDLE
- in_block  in  64  [63:32] = L0, [31:0] = R0
- decrypt  in  1  sampled with in_block at accept; selects the subkey order
- f_r  out  32  current R half, driven to the f-function; equals the R register
- key_sel  out  4  subkey index for the current round, to the key schedule
- f_p  in  32  P-box output for f_r with subkey key_sel; combinational, same cycle
- out_valid  out  1  out_block holds a finished result
- out_ready  in  1  downstream accepts out_block
- out_block  out  64  {R16, L16}; registered
- busy  out  1  high in ROUND and DONE

## Operation
- Registers: L[31:0], R[31:0], cnt[3:0], dec_q, and state ∈ {IDLE, ROUND, DONE}.
- Reset: state = IDLE; L, R, cnt and dec_q = 0.
- Output values under reset: in_ready = 1, out_valid = 0, busy = 0, f_r = 0, key_sel = 0, out_block = 0.
- IDLE:
  - in_ready = 1.
  - When in_valid & in_ready: L ← in_block[63:32], R ← in_block[31:0], dec_q ← decrypt, cnt ← 0, go to ROUND.
- ROUND, every cycle:
  - L ← R; R ← L ^ f_p; cnt ← cnt + 1.
  - key_sel = dec_q ? (15 − cnt) : cnt.
  - The update with cnt == 15 is the 16th round and moves state to DONE; cnt wraps to 0.
- DONE:
  - out_valid = 1; out_block = {R, L} (a combinational swap of the registers).
  - The registers hold their values while out_ready = 0.
  - When out_ready = 1: go to IDLE. L, R and cnt are left unchanged.
- key_sel = 0 outside ROUND.
- f_r always equals R; f_p is ignored outside ROUND.
- All XOR is bitwise at 32 bits; there is no arithmetic other than the 4-bit counter.
- Boundary conditions:
  - in_valid while busy: ignored. in_ready = 0, so no handshake occurs.
  - decrypt changing mid-operation: no effect; only dec_q is used.
  - rst mid-ROUND or mid-DONE: the block is discarded. On the next cycle the engine is in IDLE with reset values, and out_valid never pulses for the aborted block.
  - out_ready high outside DONE: no effect.
  - A block cannot be accepted in the same cycle as the DONE handshake. It is accepted on the following cycle in IDLE.

## Timing
- Accept handshake on edge 0.
- ROUND is active for the cycles following edges 0 to 15, one round per cycle, 16 in total.
- out_valid rises after edge 16, which is 16 cycles of latency from accept to valid.
- With out_ready held high:
  - One cycle in DONE.
  - in_ready is back to 1 one cycle later.
  - Minimum block period is 18 cycles.
- f_r and key_sel are registered-state outputs, stable for the whole cycle. The f-function plus P-box must settle within one clock period.
- out_block and out_valid are stable from DONE entry until the handshake.

## Test plan
- Reset values: hold rst for 2 cycles with random inputs.
  - Required: in_ready = 1, out_valid = 0, busy = 0, f_r = 0, key_sel = 0, out_block = 0.
- Zero f-function (f_p ≡ 0), in_block = 0x0123456789ABCDEF, decrypt = 0.
  - Required: key_sel steps 0 through 15.
  - Required: out_valid rises 16 cycles after accept, with out_block = 0x89ABCDEF01234567.
- Full DES encrypt: bench f-model, key 0x133457799BBCDFF1, in_block = 0xCC00CCFFF0AAF0AA, decrypt = 0.
  - Required: out_block = 0x0A4CD99543423234.
- Decrypt: same key, in_block = 0x0A4CD99543423234, decrypt = 1.
  - Required: key_sel steps 15 down to 0.
  - Required: out_block = 0xCC00CCFFF0AAF0AA.
- Backpressure and busy-ignore:
  - Hold out_ready = 0 for 5 cycles in DONE. Required: out_valid and out_block stay constant, and in_ready = 0.
  - Assert in_valid during ROUND. Required: the block is not accepted.
  - Release out_ready. Required: in_ready = 1 on the next cycle.
- Reset mid-operation: assert rst during round 7 (cnt = 7).
  - Required: the next cycle is IDLE with all reset values.
  - Required: no out_valid pulse follows.
  - Required: a fresh block is then processed to the correct result.
